// File: rtl/mips_pkg.sv
// Shared definitions for the Tiny-MIPS multicycle controller: opcodes,
// funct codes, ALU-control encodings, datapath mux encodings and FSM states.
package mips_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU control encodings; branch compare uses its own subtract code
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_BSUB = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // ALU B-operand source
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Immediate extension
  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // Operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_OR    = 2'd1,
    ALUOP_BSUB  = 2'd2,
    ALUOP_FUNCT = 2'd3
  } aluop_e;

  // Controller states; encodings are visible on state_dbg
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU control decoder: maps an operation class plus the R-type funct field
// to a 3-bit ALU control code. funct_ok flags the supported R-type functs
// and does not depend on the operation class.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  aluop_e      alu_op,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_ctrl,
  output logic        funct_ok
);

  // Decode funct into an ALU code and a legality flag
  logic [2:0] funct_ctrl;
  always_comb begin
    funct_ctrl = ALU_ADD;
    funct_ok   = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: funct_ctrl = ALU_ADD;
      FN_SUB, FN_SUBU: funct_ctrl = ALU_SUB;
      FN_AND:          funct_ctrl = ALU_AND;
      FN_OR:           funct_ctrl = ALU_OR;
      FN_SLT:          funct_ctrl = ALU_SLT;
      default: begin
        funct_ctrl = ALU_ADD;
        funct_ok   = 1'b0;
      end
    endcase
  end

  // Select the final ALU code from the operation class
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_ctrl = ALU_ADD;
      ALUOP_OR:    alu_ctrl = ALU_OR;
      ALUOP_BSUB:  alu_ctrl = ALU_BSUB;
      ALUOP_FUNCT: alu_ctrl = funct_ctrl;
      default:     alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle Moore controller for the Tiny-MIPS datapath. Each instruction
// takes 3-5 states sharing one ALU and one memory port. All outputs are
// decoded from the registered state; only ir_write and pc_en also look at
// the live mem_ready / zero inputs.
//
// Memory handshake: mem_req is high for every cycle of FETCH, MEMRD and
// MEMWR. The access completes in the first cycle where mem_req and
// mem_ready are both high; the FSM leaves the memory state at that clock
// edge. mem_ready is ignored in any cycle where mem_req is low, and while
// rst_n is low it is treated as 0 so no strobe can fire during reset.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned ALUCTRL_W   = 3,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          BNE_EN      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_ext,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal,
  output logic [3:0]           state_dbg
);

  state_e     state;
  state_e     next_state;
  aluop_e     alu_op;
  logic [2:0] alu_ctrl3;
  logic       funct_ok;
  logic       ready_eff;

  // Reset forces "not ready" so FETCH strobes stay low while rst_n is low
  assign ready_eff = rst_n & (MEM_WAIT_EN ? mem_ready : 1'b1);

  mips_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl3),
    .funct_ok (funct_ok)
  );

  assign alu_control = ALUCTRL_W'(alu_ctrl3);
  assign state_dbg   = state;

  // State register with asynchronous abort back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Per-state datapath controls and next-state selection
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    imm_ext    = EXT_SIGN;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = ready_eff;
        pc_en     = ready_eff;
        if (ready_eff) next_state = S_DECODE;
      end
      S_DECODE: begin
        // PC + (imm<<2) is computed here so BRANCH can use ALUOut
        alu_src_b  = SRCB_IMMSH;
        next_state = S_FETCH;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) next_state = S_EXEC;
            else          illegal    = 1'b1;
          end
          OP_BEQ: next_state = S_BRANCH;
          OP_BNE: begin
            if (BNE_EN) next_state = S_BRANCH;
            else        illegal    = 1'b1;
          end
          OP_ADDI, OP_ORI, OP_LUI: next_state = S_IMMEXEC;
          OP_J:    next_state = S_JUMP;
          default: illegal    = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (ready_eff) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (ready_eff) next_state = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_BSUB;
        pc_src     = PCSRC_ALUOUT;
        pc_en      = (BNE_EN && op == OP_BNE) ? ~zero : zero;
        next_state = S_FETCH;
      end
      S_IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (op == OP_ORI) begin
          imm_ext = EXT_ZERO;
          alu_op  = ALUOP_OR;
        end else if (op == OP_LUI) begin
          // B operand already holds imm<<16, so OR with rs=$0 yields the result
          imm_ext = EXT_UPPER;
          alu_op  = ALUOP_OR;
        end
        next_state = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a default instance plus one with a wide
// ALU-control bus, memory waits disabled and bne disabled. Each instruction
// is run to completion and summarised, then compared with an
// instruction-level model of cycle counts, strobe counts and key controls.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_LUI  = 6'b001111;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance 0 (defaults)
  logic [5:0] op0, funct0;
  logic       zero0, mr0;
  logic       mem_req0, iord0, mem_write0, ir_write0, pc_en0, reg_dst0;
  logic       mem_to_reg0, reg_write0, alu_src_a0, illegal0;
  logic [1:0] pc_src0, alu_src_b0, imm_ext0;
  logic [2:0] alu_control0;
  logic [3:0] state_dbg0;

  // instance 1 (ALUCTRL_W=5, no memory waits, no bne)
  logic [5:0] op1, funct1;
  logic       zero1, mr1;
  logic       mem_req1, iord1, mem_write1, ir_write1, pc_en1, reg_dst1;
  logic       mem_to_reg1, reg_write1, alu_src_a1, illegal1;
  logic [1:0] pc_src1, alu_src_b1, imm_ext1;
  logic [4:0] alu_control1;
  logic [3:0] state_dbg1;

  mips_multicycle_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .op(op0), .funct(funct0), .zero(zero0),
    .mem_ready(mr0), .mem_req(mem_req0), .iord(iord0), .mem_write(mem_write0),
    .ir_write(ir_write0), .pc_en(pc_en0), .pc_src(pc_src0), .reg_dst(reg_dst0),
    .mem_to_reg(mem_to_reg0), .reg_write(reg_write0), .alu_src_a(alu_src_a0),
    .alu_src_b(alu_src_b0), .imm_ext(imm_ext0), .alu_control(alu_control0),
    .illegal(illegal0), .state_dbg(state_dbg0)
  );

  mips_multicycle_ctrl #(.ALUCTRL_W(5), .MEM_WAIT_EN(1'b0), .BNE_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op1), .funct(funct1), .zero(zero1),
    .mem_ready(mr1), .mem_req(mem_req1), .iord(iord1), .mem_write(mem_write1),
    .ir_write(ir_write1), .pc_en(pc_en1), .pc_src(pc_src1), .reg_dst(reg_dst1),
    .mem_to_reg(mem_to_reg1), .reg_write(reg_write1), .alu_src_a(alu_src_a1),
    .alu_src_b(alu_src_b1), .imm_ext(imm_ext1), .alu_control(alu_control1),
    .illegal(illegal1), .state_dbg(state_dbg1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-instruction summary (observed or expected)
  typedef struct {
    int         cycles;
    int         n_irw, n_pcen, n_regw, n_memw, n_ill;
    int         last_state;
    logic [1:0] last_pc_src;
    logic [4:0] last_alu, prev_alu;
    logic [1:0] prev_imm;
    logic       wb_reg_dst, wb_mem_to_reg;
    bit         timeout;
    bit         chk_prev, chk_imm, chk_branch, chk_jump;
  } rec_t;

  rec_t obs, exp_r;

  // ---------------- reference model ----------------
  function automatic rec_t model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input int fw, input int mw, input bit wait_en, input bit bne_en);
    rec_t r;
    int fwe, mwe;
    logic [4:0] ra;
    bit rok;
    r = '{default:0};
    fwe = wait_en ? fw : 0;
    mwe = wait_en ? mw : 0;
    r.n_irw  = 1;
    r.n_pcen = 1;
    rok = 1'b1;
    case (f)
      6'b100000, 6'b100001: ra = 5'd2;
      6'b100010, 6'b100011: ra = 5'd5;
      6'b100100:            ra = 5'd0;
      6'b100101:            ra = 5'd1;
      6'b101010:            ra = 5'd7;
      default: begin ra = 5'd0; rok = 1'b0; end
    endcase
    if (o == T_LW) begin
      r.cycles = 5 + fwe + mwe; r.n_regw = 1; r.wb_mem_to_reg = 1'b1; r.last_state = 4;
    end else if (o == T_SW) begin
      r.cycles = 4 + fwe + mwe; r.n_memw = mwe + 1; r.last_state = 5;
    end else if (o == T_R && rok) begin
      r.cycles = 4 + fwe; r.n_regw = 1; r.wb_reg_dst = 1'b1; r.last_state = 7;
      r.prev_alu = ra; r.chk_prev = 1'b1;
    end else if (o == T_BEQ || (o == T_BNE && bne_en)) begin
      r.cycles = 3 + fwe; r.last_state = 8; r.chk_branch = 1'b1;
      r.last_pc_src = 2'b01; r.last_alu = 5'd6;
      if ((o == T_BEQ) ? z : !z) r.n_pcen = 2;
    end else if (o == T_ADDI || o == T_ORI || o == T_LUI) begin
      r.cycles = 4 + fwe; r.n_regw = 1; r.last_state = 10;
      r.chk_prev = 1'b1; r.chk_imm = 1'b1;
      r.prev_alu = (o == T_ADDI) ? 5'd2 : 5'd1;
      r.prev_imm = (o == T_ADDI) ? 2'b00 : ((o == T_ORI) ? 2'b01 : 2'b10);
    end else if (o == T_J) begin
      r.cycles = 3 + fwe; r.last_state = 11; r.n_pcen = 2;
      r.chk_jump = 1'b1; r.last_pc_src = 2'b10;
    end else begin
      r.cycles = 2 + fwe; r.n_ill = 1; r.last_state = 1;
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the chosen instance in FETCH; returns at
  // the falling edge of the next FETCH, leaving mem_ready low.
  task automatic run_instr(input int inst, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fw, input int mw);
    int left, cyc;
    bit left_fetch, done;
    logic [3:0] st;
    logic mrq, rw, mwr, iw, pe, il, rd, m2r;
    logic [1:0] ps, ie, last_ie;
    logic [4:0] ac;
    obs = '{default:0};
    if (inst == 0) begin op0 = o; funct0 = f; zero0 = z; end
    else           begin op1 = o; funct1 = f; zero1 = z; end
    left = fw; cyc = 0; left_fetch = 1'b0; done = 1'b0; last_ie = 2'b00;
    for (int c = 0; c < 60 && !done; c++) begin
      st  = (inst == 0) ? state_dbg0 : state_dbg1;
      mrq = (inst == 0) ? mem_req0 : mem_req1;
      if (left_fetch && st == 4'd0) begin
        done = 1'b1;
      end else begin
        if (st != 4'd0) left_fetch = 1'b1;
        if (inst == 0) begin
          if (mrq) begin
            if (left > 0) begin mr0 = 1'b0; left--; end
            else begin mr0 = 1'b1; left = mw; end
          end else begin
            mr0 = 1'($urandom_range(0, 1));
          end
        end else begin
          mr1 = 1'b0;
        end
        #1;
        if (inst == 0) begin
          rw = reg_write0; mwr = mem_write0; iw = ir_write0; pe = pc_en0; il = illegal0;
          rd = reg_dst0; m2r = mem_to_reg0; ps = pc_src0; ie = imm_ext0; ac = {2'b00, alu_control0};
        end else begin
          rw = reg_write1; mwr = mem_write1; iw = ir_write1; pe = pc_en1; il = illegal1;
          rd = reg_dst1; m2r = mem_to_reg1; ps = pc_src1; ie = imm_ext1; ac = alu_control1;
        end
        cyc++;
        obs.n_regw += int'(rw);
        obs.n_memw += int'(mwr);
        obs.n_irw  += int'(iw);
        obs.n_pcen += int'(pe);
        obs.n_ill  += int'(il);
        if (rw) begin obs.wb_reg_dst = rd; obs.wb_mem_to_reg = m2r; end
        obs.prev_alu    = obs.last_alu;
        obs.prev_imm    = last_ie;
        obs.last_alu    = ac;
        last_ie         = ie;
        obs.last_state  = int'(st);
        obs.last_pc_src = ps;
        @(negedge clk);
      end
    end
    mr0 = 1'b0;
    mr1 = 1'b0;
    obs.cycles  = cyc;
    obs.timeout = !done;
  endtask

  // Pulse reset; returns at the falling edge where rst_n is released
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mr0 = 1'b0; mr1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    mr0 = 1'b1; mr1 = 1'b1;
    #1;
    n_tests++;
    if (state_dbg0 !== 4'd0) begin n_fail++; $display("FAIL reset_state0 got %0d exp 0", state_dbg0); end
    n_tests++;
    if ({ir_write0, pc_en0, reg_write0, mem_write0, illegal0} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes0 got %b exp 00000", {ir_write0, pc_en0, reg_write0, mem_write0, illegal0});
    end
    n_tests++;
    if ({state_dbg1, ir_write1, pc_en1, reg_write1, mem_write1, illegal1} !== 9'b0) begin
      n_fail++; $display("FAIL reset_inst1 got %b exp 0", {state_dbg1, ir_write1, pc_en1, reg_write1, mem_write1, illegal1});
    end
    mr0 = 1'b0; mr1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_decode();
    op0 = T_LW; funct0 = 6'd0; zero0 = 1'b0; mr0 = 1'b1;
    #1;
    n_tests++;
    if (ir_write0 !== 1'b1) begin n_fail++; $display("FAIL mid_fetch_irw got %b exp 1", ir_write0); end
    @(negedge clk);
    mr0 = 1'b0;
    #1;
    n_tests++;
    if (state_dbg0 !== 4'd1) begin n_fail++; $display("FAIL mid_decode_state got %0d exp 1", state_dbg0); end
    rst_n = 1'b0; mr0 = 1'b1;
    #1;
    n_tests++;
    if (state_dbg0 !== 4'd0) begin n_fail++; $display("FAIL mid_reset_state got %0d exp 0", state_dbg0); end
    n_tests++;
    if ({ir_write0, pc_en0, reg_write0, mem_write0, illegal0} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset_strobes got %b exp 00000", {ir_write0, pc_en0, reg_write0, mem_write0, illegal0});
    end
    @(negedge clk);
    rst_n = 1'b1; mr0 = 1'b0;
    #1;
    n_tests++;
    if ({state_dbg0, mem_req0} !== 5'b00001) begin
      n_fail++; $display("FAIL mid_release got state %0d mem_req %b exp 0/1", state_dbg0, mem_req0);
    end
    @(negedge clk);
    run_instr(0, T_ADDI, 6'd0, 1'b0, 1, 0);
    n_tests++;
    if (obs.cycles !== 5 || obs.n_regw !== 1 || obs.timeout) begin
      n_fail++; $display("FAIL resume_addi got cycles %0d regw %0d exp 5/1", obs.cycles, obs.n_regw);
    end
  endtask

  task automatic test_lw_waits();
    run_instr(0, T_LW, 6'($urandom), 1'($urandom), 2, 1);
    n_tests++;
    if (obs.cycles !== 8) begin n_fail++; $display("FAIL lw_cycles got %0d exp 8", obs.cycles); end
    n_tests++;
    if (obs.n_regw !== 1 || obs.wb_mem_to_reg !== 1'b1) begin
      n_fail++; $display("FAIL lw_writeback got regw %0d m2r %b exp 1/1", obs.n_regw, obs.wb_mem_to_reg);
    end
  endtask

  task automatic test_sw_waits();
    run_instr(0, T_SW, 6'd0, 1'b0, 0, 2);
    n_tests++;
    if (obs.cycles !== 6 || obs.n_memw !== 3 || obs.n_regw !== 0) begin
      n_fail++; $display("FAIL sw_waits got cycles %0d memw %0d regw %0d exp 6/3/0", obs.cycles, obs.n_memw, obs.n_regw);
    end
  endtask

  task automatic test_branch();
    run_instr(0, T_BEQ, 6'd0, 1'b1, 0, 0);
    n_tests++;
    if (obs.n_pcen !== 2 || obs.last_pc_src !== 2'b01 || obs.last_alu !== 5'd6) begin
      n_fail++; $display("FAIL beq_taken got pcen %0d pc_src %b alu %0d exp 2/01/6", obs.n_pcen, obs.last_pc_src, obs.last_alu);
    end
    run_instr(0, T_BNE, 6'd0, 1'b1, 0, 0);
    n_tests++;
    if (obs.n_pcen !== 1 || obs.cycles !== 3) begin
      n_fail++; $display("FAIL bne_not_taken got pcen %0d cycles %0d exp 1/3", obs.n_pcen, obs.cycles);
    end
    run_instr(0, T_BNE, 6'd0, 1'b0, 1, 0);
    n_tests++;
    if (obs.n_pcen !== 2 || obs.cycles !== 4) begin
      n_fail++; $display("FAIL bne_taken got pcen %0d cycles %0d exp 2/4", obs.n_pcen, obs.cycles);
    end
  endtask

  task automatic test_imm();
    run_instr(0, T_ORI, 6'd0, 1'b0, 0, 0);
    n_tests++;
    if (obs.prev_imm !== 2'b01 || obs.prev_alu !== 5'd1) begin
      n_fail++; $display("FAIL ori_exec got ext %b alu %0d exp 01/1", obs.prev_imm, obs.prev_alu);
    end
    run_instr(0, T_LUI, 6'd0, 1'b0, 0, 0);
    n_tests++;
    if (obs.prev_imm !== 2'b10 || obs.prev_alu !== 5'd1) begin
      n_fail++; $display("FAIL lui_exec got ext %b alu %0d exp 10/1", obs.prev_imm, obs.prev_alu);
    end
  endtask

  task automatic test_rtype();
    run_instr(0, T_R, 6'b100001, 1'b0, 0, 0);
    n_tests++;
    if (obs.prev_alu !== 5'd2 || obs.wb_reg_dst !== 1'b1 || obs.n_regw !== 1) begin
      n_fail++; $display("FAIL addu got alu %0d reg_dst %b regw %0d exp 2/1/1", obs.prev_alu, obs.wb_reg_dst, obs.n_regw);
    end
    run_instr(0, T_R, 6'b000000, 1'b0, 0, 0);
    n_tests++;
    if (obs.n_ill !== 1 || obs.n_regw !== 0 || obs.cycles !== 2) begin
      n_fail++; $display("FAIL bad_funct got ill %0d regw %0d cycles %0d exp 1/0/2", obs.n_ill, obs.n_regw, obs.cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[11];
    logic [5:0] fns[8];
    logic [5:0] o, f;
    logic z;
    int fw, mw;
    ops = '{T_LW, T_SW, T_R, T_R, T_BEQ, T_BNE, T_ADDI, T_ORI, T_LUI, T_J, 6'd0};
    fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'd0};
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 10) == 10) o = 6'($urandom);
      f = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 7) f = 6'($urandom);
      z = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      exp_r = model(o, f, z, fw, mw, 1'b1, 1'b1);
      run_instr(0, o, f, z, fw, mw);
      n_tests++;
      if (obs.timeout || obs.cycles !== exp_r.cycles || obs.last_state !== exp_r.last_state) begin
        n_fail++; $display("FAIL b2b_flow[%0d] op %b got cycles %0d last %0d exp %0d/%0d", i, o, obs.cycles, obs.last_state, exp_r.cycles, exp_r.last_state);
      end
      n_tests++;
      if ({obs.n_irw, obs.n_pcen, obs.n_regw, obs.n_memw, obs.n_ill} !== {exp_r.n_irw, exp_r.n_pcen, exp_r.n_regw, exp_r.n_memw, exp_r.n_ill}) begin
        n_fail++; $display("FAIL b2b_strobes[%0d] op %b got irw %0d pcen %0d regw %0d memw %0d ill %0d exp %0d %0d %0d %0d %0d", i, o,
                           obs.n_irw, obs.n_pcen, obs.n_regw, obs.n_memw, obs.n_ill,
                           exp_r.n_irw, exp_r.n_pcen, exp_r.n_regw, exp_r.n_memw, exp_r.n_ill);
      end
      if (exp_r.n_regw > 0) begin
        n_tests++;
        if (obs.wb_reg_dst !== exp_r.wb_reg_dst || obs.wb_mem_to_reg !== exp_r.wb_mem_to_reg) begin
          n_fail++; $display("FAIL b2b_wb[%0d] got dst %b m2r %b exp %b %b", i, obs.wb_reg_dst, obs.wb_mem_to_reg, exp_r.wb_reg_dst, exp_r.wb_mem_to_reg);
        end
      end
      if (exp_r.chk_prev) begin
        n_tests++;
        if (obs.prev_alu !== exp_r.prev_alu) begin
          n_fail++; $display("FAIL b2b_alu[%0d] op %b funct %b got %0d exp %0d", i, o, f, obs.prev_alu, exp_r.prev_alu);
        end
      end
      if (exp_r.chk_imm) begin
        n_tests++;
        if (obs.prev_imm !== exp_r.prev_imm) begin
          n_fail++; $display("FAIL b2b_ext[%0d] op %b got %b exp %b", i, o, obs.prev_imm, exp_r.prev_imm);
        end
      end
      if (exp_r.chk_branch || exp_r.chk_jump) begin
        n_tests++;
        if (obs.last_pc_src !== exp_r.last_pc_src || (exp_r.chk_branch && obs.last_alu !== exp_r.last_alu)) begin
          n_fail++; $display("FAIL b2b_pc[%0d] op %b got pc_src %b alu %0d exp %b %0d", i, o, obs.last_pc_src, obs.last_alu, exp_r.last_pc_src, exp_r.last_alu);
        end
      end
    end
  endtask

  task automatic test_params();
    do_reset();
    run_instr(1, T_R, 6'b101010, 1'b0, 0, 0);
    n_tests++;
    if (obs.prev_alu !== 5'b00111 || obs.cycles !== 4) begin
      n_fail++; $display("FAIL wide_slt got alu %b cycles %0d exp 00111/4", obs.prev_alu, obs.cycles);
    end
    do_reset();
    run_instr(1, T_LW, 6'd0, 1'b0, 2, 2);
    n_tests++;
    if (obs.cycles !== 5 || obs.n_regw !== 1) begin
      n_fail++; $display("FAIL nowait_lw got cycles %0d regw %0d exp 5/1", obs.cycles, obs.n_regw);
    end
    do_reset();
    run_instr(1, T_BNE, 6'd0, 1'b0, 0, 0);
    n_tests++;
    if (obs.n_ill !== 1 || obs.n_pcen !== 1 || obs.cycles !== 2) begin
      n_fail++; $display("FAIL bne_disabled got ill %0d pcen %0d cycles %0d exp 1/1/2", obs.n_ill, obs.n_pcen, obs.cycles);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    op0 = 6'd0; funct0 = 6'd0; zero0 = 1'b0; mr0 = 1'b0;
    op1 = 6'd0; funct1 = 6'd0; zero1 = 1'b0; mr1 = 1'b0;
    test_reset();
    test_reset_mid_decode();
    test_lw_waits();
    test_sw_waits();
    test_branch();
    test_imm();
    test_rtype();
    test_back_to_back();
    test_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
